// File: rtl/seven_seg_capture.sv
// Receive side of the multiplexed seven-segment bus: rebuilds the hi/lo pattern
// pair from alternating strobes, decodes both digits and supervises strobe cadence.
module seven_seg_capture #(
  parameter int unsigned FREQ  = 15000,
  parameter int unsigned CBITS = 16,
  parameter int unsigned TMO   = 2 * FREQ + 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  segment,
  input  logic        sig,
  output logic [13:0] both7seg_out,
  output logic [3:0]  hi_nib,
  output logic [3:0]  lo_nib,
  output logic        pair_valid,
  output logic        dec_err,
  output logic        locked,
  output logic        timeout
);

  localparam logic [CBITS-1:0] TMO_C    = CBITS'(TMO);
  localparam logic [CBITS-1:0] TMO_M1_C = CBITS'(TMO - 1);
  localparam logic [CBITS-1:0] ONE_C    = CBITS'(1);

  typedef enum logic [1:0] {
    WAIT_HI = 2'd0,
    WAIT_LO = 2'd1,
    LOST    = 2'd2
  } state_t;

  state_t           state;
  logic [CBITS-1:0] gap;
  logic [6:0]       hi_hold;
  logic [4:0]       hi_dec_c;
  logic [4:0]       lo_dec_c;

  // Pattern to {illegal, nibble}; anything outside the hex font is illegal and reads as 0.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F:   decode = 5'h00;
      7'h06:   decode = 5'h01;
      7'h5B:   decode = 5'h02;
      7'h4F:   decode = 5'h03;
      7'h66:   decode = 5'h04;
      7'h6D:   decode = 5'h05;
      7'h7D:   decode = 5'h06;
      7'h07:   decode = 5'h07;
      7'h7F:   decode = 5'h08;
      7'h6F:   decode = 5'h09;
      7'h77:   decode = 5'h0A;
      7'h7C:   decode = 5'h0B;
      7'h39:   decode = 5'h0C;
      7'h5E:   decode = 5'h0D;
      7'h79:   decode = 5'h0E;
      7'h71:   decode = 5'h0F;
      default: decode = 5'h10;
    endcase
  endfunction

  assign hi_dec_c = decode(hi_hold);
  assign lo_dec_c = decode(segment);

  // Capture FSM and cadence supervisor; a strobe always beats a coincident timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= WAIT_HI;
      gap          <= '0;
      hi_hold      <= '0;
      both7seg_out <= '0;
      hi_nib       <= '0;
      lo_nib       <= '0;
      pair_valid   <= 1'b0;
      dec_err      <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      pair_valid <= 1'b0;
      if (sig) begin
        gap <= '0;
        case (state)
          WAIT_HI: begin
            hi_hold <= segment;
            state   <= WAIT_LO;
          end
          WAIT_LO: begin
            both7seg_out <= {hi_hold, segment};
            hi_nib       <= hi_dec_c[3:0];
            lo_nib       <= lo_dec_c[3:0];
            dec_err      <= hi_dec_c[4] | lo_dec_c[4];
            pair_valid   <= 1'b1;
            locked       <= 1'b1;
            state        <= WAIT_HI;
          end
          LOST: begin
            timeout <= 1'b0;
            hi_hold <= segment;
            state   <= WAIT_LO;
          end
          default: state <= WAIT_HI;
        endcase
      end else if (gap != TMO_C) begin
        gap <= gap + ONE_C;
        if (gap == TMO_M1_C) begin
          timeout <= 1'b1;
          locked  <= 1'b0;
          hi_hold <= '0;
          state   <= LOST;
        end
      end
    end
  end

endmodule
